// File: rtl/mapper_mem_arbiter_if.sv
// Request/response bundle between the three cart-memory requesters, the arbiter and the
// SDRAM controller port.
interface mapper_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 22
);
  logic              chr_req;
  logic [ADDR_W-1:0] chr_addr;
  logic              chr_we;
  logic [7:0]        chr_wdata;
  logic              chr_ack;
  logic [7:0]        chr_rdata;

  logic              prg_req;
  logic [ADDR_W-1:0] prg_addr;
  logic              prg_we;
  logic [7:0]        prg_wdata;
  logic              prg_ack;
  logic [7:0]        prg_rdata;

  logic              ss_req;
  logic [ADDR_W-1:0] ss_addr;
  logic              ss_we;
  logic [7:0]        ss_wdata;
  logic              ss_ack;
  logic [7:0]        ss_rdata;

  logic              mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // Arbiter side.
  modport slave (
    input  chr_req, chr_addr, chr_we, chr_wdata,
    input  prg_req, prg_addr, prg_we, prg_wdata,
    input  ss_req, ss_addr, ss_we, ss_wdata,
    input  mem_rdata,
    output chr_ack, chr_rdata, prg_ack, prg_rdata, ss_ack, ss_rdata,
    output mem_cmd, mem_addr, mem_we, mem_wdata
  );

  // Requesters plus memory controller side.
  modport master (
    output chr_req, chr_addr, chr_we, chr_wdata,
    output prg_req, prg_addr, prg_we, prg_wdata,
    output ss_req, ss_addr, ss_we, ss_wdata,
    output mem_rdata,
    input  chr_ack, chr_rdata, prg_ack, prg_rdata, ss_ack, ss_rdata,
    input  mem_cmd, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mapper_mem_arbiter.sv
// Strict-priority (CHR > PRG > SS) arbiter for the single cart SDRAM port, fixed read latency.
// Optional SS anti-starvation counter enabled by defining MEM_ARB_ANTISTARVE_EN.
module mapper_mem_arbiter #(
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned LAT          = 2,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input logic                 clk,
  input logic                 reset_n,
  mapper_mem_arbiter_if.slave bus
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
  localparam logic [3:0] LatCnt = 4'(LAT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        owner_q;
  logic [2:0]        req, elig, gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [7:0]        sel_wdata;
  logic              rd_sample;
  logic              ss_starved;

  logic              mem_cmd_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic [2:0]        ack_q;
  logic [7:0]        chr_rdata_q, prg_rdata_q, ss_rdata_q;

  assign req       = {bus.ss_req, bus.prg_req, bus.chr_req};
  assign rd_sample = (state_q == StWait) && (cnt_q == 4'd0);

`ifdef MEM_ARB_ANTISTARVE_EN
  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);
  logic [7:0] starve_q;
  logic       ss_busy;

  // SS's own transaction in flight does not count as waiting.
  assign ss_busy    = (state_q != StIdle) && owner_q[2];
  assign ss_starved = (starve_q >= StarveLimit);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_q <= 8'd0;
    end else if (!bus.ss_req || gnt[2]) begin
      starve_q <= 8'd0;
    end else if (!ss_busy && (starve_q != 8'hff)) begin
      starve_q <= starve_q + 8'd1;
    end
  end
`else
  assign ss_starved = 1'b0;
`endif

  // DONE doubles as an arbitration cycle with the just-acked requester masked.
  always_comb begin
    elig = 3'b000;
    if (state_q == StIdle) begin
      elig = req;
    end else if (state_q == StDone) begin
      elig = req & ~owner_q;
    end
    gnt = 3'b000;
    if (ss_starved && elig[2]) gnt = 3'b100;
    else if (elig[0])          gnt = 3'b001;
    else if (elig[1])          gnt = 3'b010;
    else if (elig[2])          gnt = 3'b100;
  end

  always_comb begin
    sel_addr  = bus.chr_addr;
    sel_we    = bus.chr_we;
    sel_wdata = bus.chr_wdata;
    if (gnt[1]) begin
      sel_addr  = bus.prg_addr;
      sel_we    = bus.prg_we;
      sel_wdata = bus.prg_wdata;
    end else if (gnt[2]) begin
      sel_addr  = bus.ss_addr;
      sel_we    = bus.ss_we;
      sel_wdata = bus.ss_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (|gnt) begin
          state_d = StWait;
          cnt_d   = LatCnt;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      owner_q     <= 3'b000;
      mem_cmd_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'd0;
      ack_q       <= 3'b000;
      chr_rdata_q <= 8'd0;
      prg_rdata_q <= 8'd0;
      ss_rdata_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_cmd_q <= |gnt;
      ack_q     <= 3'b000;
      if (|gnt) begin
        owner_q     <= gnt;
        mem_addr_q  <= sel_addr;
        mem_we_q    <= sel_we;
        mem_wdata_q <= sel_wdata;
      end
      if (rd_sample) begin
        ack_q <= owner_q;
        if (!mem_we_q) begin
          if (owner_q[0]) chr_rdata_q <= bus.mem_rdata;
          if (owner_q[1]) prg_rdata_q <= bus.mem_rdata;
          if (owner_q[2]) ss_rdata_q  <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_cmd   = mem_cmd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.chr_ack   = ack_q[0];
  assign bus.prg_ack   = ack_q[1];
  assign bus.ss_ack    = ack_q[2];
  assign bus.chr_rdata = chr_rdata_q;
  assign bus.prg_rdata = prg_rdata_q;
  assign bus.ss_rdata  = ss_rdata_q;
endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Bench for mapper_mem_arbiter: transaction-age model checked every cycle plus directed
// literal checks. Honours MEM_ARB_ANTISTARVE_EN for the starvation scenario.
module tb_mapper_mem_arbiter;
  localparam int unsigned ADDR_W       = 22;
  localparam int          LAT          = 2;
  localparam int          STARVE_LIMIT = 15;

  logic clk = 1'b0;
  logic reset_n;

  mapper_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mapper_mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .LAT          (LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0  = 0;
  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Memory responder: data = addr[7:0]^B5 exactly LAT cycles after mem_cmd, junk otherwise.
  int         due = -1;
  logic [7:0] rd_val = 8'h00;
  always @(negedge clk) begin
    if (bus.mem_cmd === 1'b1) begin
      due    = cyc + LAT;
      rd_val = bus.mem_addr[7:0] ^ 8'hB5;
    end
  end
  always @(posedge clk) begin
    #1;
    bus.mem_rdata = (cyc == due) ? rd_val : 8'hEE;
  end

  // Model: tracks each transaction by its age in cycles since the pick cycle.
  logic              e_cmd, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_wdata;
  logic [2:0]        e_ack;
  logic [7:0]        e_rd [3];
  logic [2:0]        m_req, m_el;
  bit                m_busy;
  int                m_age, m_owner, m_starve;

  always @(posedge clk) begin
    int w;
    bit arb;
    e_ack = 3'b000;
    e_cmd = 1'b0;
    if (!reset_n) begin
      e_we    = 1'b0;
      e_addr  = '0;
      e_wdata = 8'h00;
      for (int i = 0; i < 3; i++) e_rd[i] = 8'h00;
      m_busy   = 1'b0;
      m_age    = 0;
      m_owner  = 0;
      m_starve = 0;
    end else begin
      m_req = {bus.ss_req, bus.prg_req, bus.chr_req};
      arb   = !m_busy || (m_age == LAT + 2);
      m_el  = arb ? m_req : 3'b000;
      if (m_busy && arb) m_el[m_owner] = 1'b0;
      if (m_busy && m_age == LAT + 1) begin
        if (!e_we) e_rd[m_owner] = bus.mem_rdata;
        e_ack[m_owner] = 1'b1;
      end
      w = -1;
      if (m_el[0])      w = 0;
      else if (m_el[1]) w = 1;
      else if (m_el[2]) w = 2;
`ifdef MEM_ARB_ANTISTARVE_EN
      if (m_el[2] && m_starve >= STARVE_LIMIT) w = 2;
      if (!bus.ss_req || w == 2) m_starve = 0;
      else if (!(m_busy && m_owner == 2) && m_starve < 255) m_starve++;
`endif
      if (w >= 0) begin
        e_cmd   = 1'b1;
        m_busy  = 1'b1;
        m_age   = 1;
        m_owner = w;
        case (w)
          0:       begin e_addr = bus.chr_addr; e_we = bus.chr_we; e_wdata = bus.chr_wdata; end
          1:       begin e_addr = bus.prg_addr; e_we = bus.prg_we; e_wdata = bus.prg_wdata; end
          default: begin e_addr = bus.ss_addr;  e_we = bus.ss_we;  e_wdata = bus.ss_wdata;  end
        endcase
      end else if (m_busy) begin
        if (arb) m_busy = 1'b0;
        else     m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mem_cmd",   32'(bus.mem_cmd),   32'(e_cmd));
      chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
      chk("mem_we",    32'(bus.mem_we),    32'(e_we));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
      chk("chr_ack",   32'(bus.chr_ack),   32'(e_ack[0]));
      chk("prg_ack",   32'(bus.prg_ack),   32'(e_ack[1]));
      chk("ss_ack",    32'(bus.ss_ack),    32'(e_ack[2]));
      chk("chr_rdata", 32'(bus.chr_rdata), 32'(e_rd[0]));
      chk("prg_rdata", 32'(bus.prg_rdata), 32'(e_rd[1]));
      chk("ss_rdata",  32'(bus.ss_rdata),  32'(e_rd[2]));
      chk("ack_onehot", 32'($countones({bus.ss_ack, bus.prg_ack, bus.chr_ack}) <= 1), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at(input int k);
    while (cyc < t0 + k) step();
    @(negedge clk);
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0:       return bus.chr_ack;
      1:       return bus.prg_ack;
      default: return bus.ss_ack;
    endcase
  endfunction

  task automatic wait_ack(input int p, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (ack_of(p) === 1'b1);
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic clear_reqs();
    bus.chr_req = 1'b0; bus.chr_addr = '0; bus.chr_we = 1'b0; bus.chr_wdata = 8'h00;
    bus.prg_req = 1'b0; bus.prg_addr = '0; bus.prg_we = 1'b0; bus.prg_wdata = 8'h00;
    bus.ss_req  = 1'b0; bus.ss_addr  = '0; bus.ss_we  = 1'b0; bus.ss_wdata  = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0;
    clear_reqs();
    step();
    step();
    started = 1'b1;
    @(negedge clk);
    chk("rst_mem_cmd",  32'(bus.mem_cmd),  32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_chr_ack",  32'(bus.chr_ack),  32'd0);
    step();
    reset_n = 1'b1;
    step();

    // 1: single CHR read
    bus.chr_req = 1'b1; bus.chr_addr = 22'h200010;
    t0 = cyc;
    at(1);
    chk("t1_mem_cmd",  32'(bus.mem_cmd),  32'd1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h200010);
    at(3);
    chk("t1_no_early_ack", 32'(bus.chr_ack), 32'd0);
    at(4);
    chk("t1_chr_ack",   32'(bus.chr_ack),   32'd1);
    chk("t1_chr_rdata", 32'(bus.chr_rdata), 32'hA5);
    step();
    bus.chr_req = 1'b0;
    repeat (3) step();

    // 2: all three at once, strict priority, no bubbles
    bus.chr_req = 1'b1; bus.chr_addr = 22'h000077;
    bus.prg_req = 1'b1; bus.prg_addr = 22'h001234;
    bus.ss_req  = 1'b1; bus.ss_addr  = 22'h3FFFFF;
    t0 = cyc;
    at(4);
    chk("t2_chr_ack",   32'(bus.chr_ack),   32'd1);
    chk("t2_chr_rdata", 32'(bus.chr_rdata), 32'hC2);
    step();
    bus.chr_req = 1'b0;
    at(5);
    chk("t2_prg_cmd_addr", 32'(bus.mem_addr), 32'h001234);
    at(8);
    chk("t2_prg_ack",   32'(bus.prg_ack),   32'd1);
    chk("t2_prg_rdata", 32'(bus.prg_rdata), 32'h81);
    step();
    bus.prg_req = 1'b0;
    at(12);
    chk("t2_ss_ack",   32'(bus.ss_ack),   32'd1);
    chk("t2_ss_rdata", 32'(bus.ss_rdata), 32'h4A);
    step();
    bus.ss_req = 1'b0;
    repeat (2) step();

    // 3: PRG write leaves prg_rdata alone
    bus.prg_req = 1'b1; bus.prg_we = 1'b1; bus.prg_addr = 22'h3C0005; bus.prg_wdata = 8'h3C;
    t0 = cyc;
    at(1);
    chk("t3_mem_we",    32'(bus.mem_we),    32'd1);
    chk("t3_mem_wdata", 32'(bus.mem_wdata), 32'h3C);
    chk("t3_mem_addr",  32'(bus.mem_addr),  32'h3C0005);
    at(4);
    chk("t3_prg_ack",   32'(bus.prg_ack),   32'd1);
    chk("t3_prg_rdata", 32'(bus.prg_rdata), 32'h81);
    step();
    bus.prg_req = 1'b0; bus.prg_we = 1'b0;
    repeat (2) step();

    // 4: reset in the middle of WAIT
    bus.chr_req = 1'b1; bus.chr_addr = 22'h000123;
    t0 = cyc;
    while (cyc < t0 + 2) step();
    reset_n = 1'b0;
    bus.chr_req = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t4_mem_cmd",   32'(bus.mem_cmd),   32'd0);
    chk("t4_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("t4_chr_rdata", 32'(bus.chr_rdata), 32'd0);
    chk("t4_prg_rdata", 32'(bus.prg_rdata), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.chr_ack === 1'b1) cnt++;
    end
    chk("t4_no_stale_ack", 32'(cnt), 32'd0);
    step();
    bus.chr_req = 1'b1; bus.chr_addr = 22'h0000F0;
    t0 = cyc;
    at(4);
    chk("t4_new_chr_ack",   32'(bus.chr_ack),   32'd1);
    chk("t4_new_chr_rdata", 32'(bus.chr_rdata), 32'h45);
    step();
    bus.chr_req = 1'b0;
    repeat (2) step();

    // 5: CHR and PRG hog the port while SS waits
    bus.chr_req = 1'b1; bus.chr_addr = 22'h000011;
    bus.prg_req = 1'b1; bus.prg_addr = 22'h000022;
    bus.ss_req  = 1'b1; bus.ss_addr  = 22'h000033;
`ifdef MEM_ARB_ANTISTARVE_EN
    wait_ack(2, STARVE_LIMIT + LAT + 4, "t5_ss_ack_by_limit");
    step();
    bus.ss_req = 1'b0;
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.ss_ack === 1'b1) cnt++;
    end
    chk("t5_ss_starved", 32'(cnt), 32'd0);
`endif
    wait_ack(0, 12, "t5_chr_ack");
    step();
    bus.chr_req = 1'b0;
    wait_ack(1, 12, "t5_prg_ack");
    step();
    bus.prg_req = 1'b0;
`ifndef MEM_ARB_ANTISTARVE_EN
    wait_ack(2, 12, "t5_ss_ack_after_release");
    step();
    bus.ss_req = 1'b0;
`endif
    repeat (3) step();

    // 6: CHR lingers past its ack while PRG waits; PRG wins the DONE cycle
    bus.chr_req = 1'b1; bus.chr_addr = 22'h000200;
    t0 = cyc;
    while (cyc < t0 + 2) step();
    bus.prg_req = 1'b1; bus.prg_addr = 22'h2ABCDE;
    at(4);
    chk("t6_chr_ack", 32'(bus.chr_ack), 32'd1);
    at(5);
    chk("t6_prg_cmd",      32'(bus.mem_cmd),  32'd1);
    chk("t6_prg_cmd_addr", 32'(bus.mem_addr), 32'h2ABCDE);
    step();
    bus.chr_req = 1'b0;
    at(8);
    chk("t6_prg_ack",   32'(bus.prg_ack),   32'd1);
    chk("t6_prg_rdata", 32'(bus.prg_rdata), 32'h6B);
    step();
    bus.prg_req = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
